// File: rtl/fixfloat_conv_sched.sv
// Shares one pipelined int-to-float converter between two 16-bit sample requesters.
// Round-robin issue with credit limit; a tag FIFO routes each result back to its owner in order.
module fixfloat_conv_sched #(
  parameter int MAX_OUT = 16,
  parameter int CW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s0_tvalid,
  output logic          s0_tready,
  input  logic [15:0]   s0_tdata,
  input  logic          s1_tvalid,
  output logic          s1_tready,
  input  logic [15:0]   s1_tdata,
  output logic          cv_a_tvalid,
  input  logic          cv_a_tready,
  output logic [31:0]   cv_a_tdata,
  input  logic          cv_r_tvalid,
  output logic          cv_r_tready,
  input  logic [31:0]   cv_r_tdata,
  output logic          m0_tvalid,
  input  logic          m0_tready,
  output logic [31:0]   m0_tdata,
  output logic          m1_tvalid,
  input  logic          m1_tready,
  output logic [31:0]   m1_tdata,
  output logic [CW-1:0] outstanding,
  output logic          err_orphan
);
  localparam int AW = $clog2(MAX_OUT);

  logic               rr;
  logic [MAX_OUT-1:0] tag_mem;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               can_load;
  logic               credit_ok;
  logic               allow;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic [15:0]        acc_dat;
  logic               fifo_empty;
  logic               head_tag;
  logic               head_free;
  logic               res_fire;
  logic               pop;
  logic               orphan;

  // Tag FIFO occupancy always equals outstanding, so the counter doubles as the fill level.
  assign fifo_empty = (outstanding == '0);
  assign head_tag   = tag_mem[rd_ptr];

  assign can_load  = !cv_a_tvalid || cv_a_tready;
  assign credit_ok = outstanding < CW'(MAX_OUT);
  assign allow     = rst_n && can_load && credit_ok;
  assign grant0    = allow && s0_tvalid && (!s1_tvalid || !rr);
  assign grant1    = allow && s1_tvalid && (!s0_tvalid || rr);
  assign accept    = grant0 || grant1;
  assign acc_dat   = grant1 ? s1_tdata : s0_tdata;
  assign s0_tready = grant0;
  assign s1_tready = grant1;

  assign head_free   = head_tag ? (!m1_tvalid || m1_tready) : (!m0_tvalid || m0_tready);
  assign cv_r_tready = rst_n && (fifo_empty || head_free);
  assign res_fire    = cv_r_tvalid && cv_r_tready;
  assign pop         = res_fire && !fifo_empty;
  assign orphan      = res_fire && fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_a_tvalid <= 1'b0;
      cv_a_tdata  <= '0;
    end else if (can_load) begin
      cv_a_tvalid <= accept;
      if (accept) cv_a_tdata <= {{16{acc_dat[15]}}, acc_dat};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_mem     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rr          <= 1'b0;
      outstanding <= '0;
      err_orphan  <= 1'b0;
    end else begin
      if (accept) begin
        tag_mem[wr_ptr] <= grant1;
        wr_ptr          <= wr_ptr + AW'(1);
        rr              <= grant0;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)      outstanding <= outstanding + CW'(1);
      else if (pop && !accept) outstanding <= outstanding - CW'(1);
      if (orphan) err_orphan <= 1'b1;
    end
  end

  // A result may load a destination in the same cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_tvalid <= 1'b0;
      m0_tdata  <= '0;
      m1_tvalid <= 1'b0;
      m1_tdata  <= '0;
    end else begin
      if (pop && !head_tag) begin
        m0_tvalid <= 1'b1;
        m0_tdata  <= cv_r_tdata;
      end else if (m0_tready) begin
        m0_tvalid <= 1'b0;
      end
      if (pop && head_tag) begin
        m1_tvalid <= 1'b1;
        m1_tdata  <= cv_r_tdata;
      end else if (m1_tready) begin
        m1_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixfloat_conv_sched.sv
// Bench for fixfloat_conv_sched: converter/sink model, per-requester scoreboard, directed and random phases.
module tb_fixfloat_conv_sched;
  localparam int MAX_OUT = 16;
  localparam int CW      = 5;
  localparam int LAT     = 6;

  logic          clk;
  logic          rst_n;
  logic          s0_tvalid, s0_tready;
  logic [15:0]   s0_tdata;
  logic          s1_tvalid, s1_tready;
  logic [15:0]   s1_tdata;
  logic          cv_a_tvalid, cv_a_tready;
  logic [31:0]   cv_a_tdata;
  logic          cv_r_tvalid, cv_r_tready;
  logic [31:0]   cv_r_tdata;
  logic          m0_tvalid, m0_tready;
  logic [31:0]   m0_tdata;
  logic          m1_tvalid, m1_tready;
  logic [31:0]   m1_tdata;
  logic [CW-1:0] outstanding;
  logic          err_orphan;

  fixfloat_conv_sched #(.MAX_OUT(MAX_OUT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
    .cv_a_tvalid(cv_a_tvalid), .cv_a_tready(cv_a_tready), .cv_a_tdata(cv_a_tdata),
    .cv_r_tvalid(cv_r_tvalid), .cv_r_tready(cv_r_tready), .cv_r_tdata(cv_r_tdata),
    .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tdata(m0_tdata),
    .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tdata(m1_tdata),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Exact for the 16-bit sample range; truncates beyond 24 significant bits.
  function automatic logic [31:0] i2f(input int v);
    longint m;
    int e;
    logic [63:0] f;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -longint'(v) : longint'(v);
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    f = (e <= 23) ? 64'(m << (23 - e)) : 64'(m >> (e - 23));
    return {(v < 0), 8'(127 + e), f[22:0]};
  endfunction

  bit rand_mode, a_hold, r_hold, m0_hold, m1_hold, inject;
  logic [31:0] inj_dat;

  typedef struct {
    logic [31:0] d;
    int          due;
  } res_t;
  res_t cq[$];

  // Converter pipeline and result sinks.
  initial begin
    bit fa, fr;
    logic [31:0] ad;
    cv_a_tready = 1'b0;
    cv_r_tvalid = 1'b0;
    cv_r_tdata  = 32'h0;
    m0_tready   = 1'b0;
    m1_tready   = 1'b0;
    forever begin
      @(negedge clk);
      fa = cv_a_tvalid && cv_a_tready;
      fr = cv_r_tvalid && cv_r_tready;
      ad = cv_a_tdata;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        cq.delete();
      end else begin
        if (fr && cq.size() > 0) void'(cq.pop_front());
        if (fa) cq.push_back('{d: i2f(int'($signed(ad))), due: cyc + LAT - 1});
        if (inject) cq.push_back('{d: inj_dat, due: cyc});
      end
      cv_a_tready = !a_hold && (!rand_mode || $urandom_range(3) != 0);
      cv_r_tvalid = !r_hold && cq.size() > 0 && cq[0].due <= cyc;
      if (cv_r_tvalid) cv_r_tdata = cq[0].d;
      else cv_r_tdata = 32'h0;
      m0_tready = !m0_hold && (!rand_mode || $urandom_range(3) != 0);
      m1_tready = !m1_hold && (!rand_mode || $urandom_range(3) != 0);
    end
  end

  logic [31:0] exp0[$], exp1[$], got0[$], got1[$];
  bit          tagq[$];
  int          occ;
  bit          err_m, rr_m, hold0, hold1;
  logic [31:0] hd0, hd1;

  // Sample-level reference: owner queue, per-requester expected floats, round-robin pointer.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp0.delete(); exp1.delete(); got0.delete(); got1.delete(); tagq.delete();
      occ = 0; err_m = 0; rr_m = 0; hold0 = 0; hold1 = 0;
    end else begin
      bit hf, g, popm;
      logic [31:0] e;
      check("outstanding", 32'(outstanding), 32'(occ));
      check("err_orphan", 32'(err_orphan), 32'(err_m));
      if (occ == 0) hf = 1'b1;
      else if (tagq[0]) hf = !m1_tvalid || m1_tready;
      else hf = !m0_tvalid || m0_tready;
      check("cv_r_tready", 32'(cv_r_tready), 32'(hf));
      check("one_grant", 32'(s0_tready & s1_tready), 32'h0);
      if (hold0) begin
        check("m0_hold_vld", 32'(m0_tvalid), 32'h1);
        check("m0_hold_dat", m0_tdata, hd0);
      end
      if (hold1) begin
        check("m1_hold_vld", 32'(m1_tvalid), 32'h1);
        check("m1_hold_dat", m1_tdata, hd1);
      end
      hold0 = m0_tvalid && !m0_tready; hd0 = m0_tdata;
      hold1 = m1_tvalid && !m1_tready; hd1 = m1_tdata;
      if (m0_tvalid && m0_tready) begin
        got0.push_back(m0_tdata);
        e = (exp0.size() > 0) ? exp0.pop_front() : ~m0_tdata;
        check("m0_data", m0_tdata, e);
      end
      if (m1_tvalid && m1_tready) begin
        got1.push_back(m1_tdata);
        e = (exp1.size() > 0) ? exp1.pop_front() : ~m1_tdata;
        check("m1_data", m1_tdata, e);
      end
      popm = cv_r_tvalid && cv_r_tready && occ > 0;
      if (cv_r_tvalid && cv_r_tready && occ == 0) err_m = 1'b1;
      if (popm) begin
        void'(tagq.pop_front());
        occ--;
      end
      if (s0_tready || s1_tready) begin
        g = s1_tready;
        check("grant_valid", 32'(g ? s1_tvalid : s0_tvalid), 32'h1);
        if (s0_tvalid && s1_tvalid) check("rr_grant", 32'(g), 32'(rr_m));
        rr_m = !g;
        tagq.push_back(g);
        occ++;
        if (g) exp1.push_back(i2f(int'($signed(s1_tdata))));
        else exp0.push_back(i2f(int'($signed(s0_tdata))));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input string p);
    check({p, "_cv_a_tvalid"}, 32'(cv_a_tvalid), 32'h0);
    check({p, "_cv_r_tready"}, 32'(cv_r_tready), 32'h0);
    check({p, "_m0_tvalid"}, 32'(m0_tvalid), 32'h0);
    check({p, "_m1_tvalid"}, 32'(m1_tvalid), 32'h0);
    check({p, "_s0_tready"}, 32'(s0_tready), 32'h0);
    check({p, "_s1_tready"}, 32'(s1_tready), 32'h0);
    check({p, "_outstanding"}, 32'(outstanding), 32'h0);
    check({p, "_err_orphan"}, 32'(err_orphan), 32'h0);
    check({p, "_cv_a_tdata"}, cv_a_tdata, 32'h0);
    check({p, "_m0_tdata"}, m0_tdata, 32'h0);
    check({p, "_m1_tdata"}, m1_tdata, 32'h0);
  endtask

  task automatic send(input bit which, input logic [15:0] d);
    bit done;
    done = 1'b0;
    if (which) begin s1_tvalid = 1'b1; s1_tdata = d; end
    else begin s0_tvalid = 1'b1; s0_tdata = d; end
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = which ? s1_tready : s0_tready;
      tick();
    end
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    check("send_accept", 32'(done), 32'h1);
  endtask

  task automatic drain(input string tag);
    bit idle;
    idle = 1'b0;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge clk);
      idle = (outstanding == '0) && !cv_a_tvalid && !m0_tvalid && !m1_tvalid;
      if (!idle) tick();
    end
    check({tag, "_idle"}, 32'(idle), 32'h1);
    check({tag, "_lost0"}, 32'(exp0.size()), 32'h0);
    check({tag, "_lost1"}, 32'(exp1.size()), 32'h0);
    tick();
  endtask

  task automatic rand_run(input int n);
    bit a0, a1;
    a0 = 1'b0;
    a1 = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!s0_tvalid || a0) begin
        s0_tvalid = ($urandom % 3) != 0;
        s0_tdata  = 16'($urandom);
      end
      if (!s1_tvalid || a1) begin
        s1_tvalid = ($urandom % 3) != 0;
        s1_tdata  = 16'($urandom);
      end
      if (($urandom % 16) == 0) r_hold = !r_hold;
      @(negedge clk);
      a0 = s0_tvalid && s0_tready;
      a1 = s1_tvalid && s1_tready;
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] v0[3];
    logic [15:0] v1[3];
    logic [31:0] f0[3];
    logic [31:0] f1[3];
    int gord[$];
    int i0, i1, acc, pop_cyc;
    bit found;

    v0 = '{16'd1, 16'd2, 16'd3};
    v1 = '{16'hFFFF, 16'hFFFE, 16'hFFFD};
    f0 = '{32'h3F800000, 32'h40000000, 32'h40400000};
    f1 = '{32'hBF800000, 32'hC0000000, 32'hC0400000};
    rand_mode = 0; a_hold = 0; r_hold = 0; m0_hold = 0; m1_hold = 0; inject = 0; inj_dat = 32'h0;

    // Reset with both requesters asserting valid.
    rst_n = 1'b0;
    s0_tvalid = 1'b1; s0_tdata = 16'h7FFF;
    s1_tvalid = 1'b1; s1_tdata = 16'h8001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    tick();
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    rst_n = 1'b1;

    // Single sample on requester 0, exact latency.
    repeat (3) tick();
    s0_tvalid = 1'b1;
    s0_tdata  = 16'h8000;
    @(negedge clk);
    check("t1_s0_tready", 32'(s0_tready), 32'h1);
    tick();
    s0_tvalid = 1'b0;
    @(negedge clk);
    check("t1_cv_a_tvalid", 32'(cv_a_tvalid), 32'h1);
    check("t1_cv_a_tdata", cv_a_tdata, 32'hFFFF8000);
    for (int k = 2; k < 8; k++) begin
      tick();
      @(negedge clk);
      check("t1_m0_early", 32'(m0_tvalid), 32'h0);
    end
    tick();
    @(negedge clk);
    check("t1_m0_tvalid", 32'(m0_tvalid), 32'h1);
    check("t1_m0_tdata", m0_tdata, 32'hC7000000);
    repeat (3) tick();
    check("t1_m1_results", 32'(got1.size()), 32'h0);
    drain("t1");

    // Both requesters streaming continuously.
    do_reset();
    i0 = 0; i1 = 0;
    for (int k = 0; k < 40 && (i0 < 3 || i1 < 3); k++) begin
      s0_tvalid = i0 < 3;
      s0_tdata  = v0[(i0 < 3) ? i0 : 0];
      s1_tvalid = i1 < 3;
      s1_tdata  = v1[(i1 < 3) ? i1 : 0];
      @(negedge clk);
      if (s0_tready) begin gord.push_back(0); i0++; end
      if (s1_tready) begin gord.push_back(1); i1++; end
      tick();
    end
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    check("t2_grants", 32'(gord.size()), 32'd6);
    for (int k = 0; k < 6 && k < gord.size(); k++) check("t2_grant_order", 32'(gord[k]), 32'(k % 2));
    drain("t2");
    check("t2_m0_count", 32'(got0.size()), 32'd3);
    check("t2_m1_count", 32'(got1.size()), 32'd3);
    for (int k = 0; k < 3 && k < got0.size(); k++) check("t2_m0_value", got0[k], f0[k]);
    for (int k = 0; k < 3 && k < got1.size(); k++) check("t2_m1_value", got1[k], f1[k]);

    // Credit limit with results held back.
    do_reset();
    r_hold = 1'b1;
    s0_tvalid = 1'b1;
    acc = 0;
    for (int k = 0; k < 30; k++) begin
      s0_tdata = 16'($urandom);
      @(negedge clk);
      if (s0_tready) acc++;
      tick();
    end
    @(negedge clk);
    check("t3_accepted", 32'(acc), 32'd16);
    check("t3_outstanding", 32'(outstanding), 32'd16);
    check("t3_s0_tready", 32'(s0_tready), 32'h0);
    tick();
    r_hold = 1'b0;
    pop_cyc = -1;
    for (int k = 0; k < 100 && acc < 20; k++) begin
      @(negedge clk);
      if (s0_tready) begin
        if (acc == 16) check("t3_17th_cycle", 32'(cyc), 32'(pop_cyc + 1));
        acc++;
      end
      if (pop_cyc < 0 && cv_r_tvalid && cv_r_tready) pop_cyc = cyc;
      tick();
      if (acc >= 20) s0_tvalid = 1'b0;
      else s0_tdata = 16'($urandom);
    end
    check("t3_total", 32'(acc), 32'd20);
    drain("t3");

    // Converter input stall.
    do_reset();
    a_hold = 1'b1;
    s0_tvalid = 1'b1;
    s0_tdata  = 16'h1234;
    @(negedge clk);
    check("t4_first_accept", 32'(s0_tready), 32'h1);
    tick();
    s0_tdata = 16'h5678;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_cv_a_tvalid", 32'(cv_a_tvalid), 32'h1);
      check("t4_cv_a_tdata", cv_a_tdata, 32'h00001234);
      check("t4_no_accept", 32'(s0_tready), 32'h0);
      check("t4_outstanding", 32'(outstanding), 32'h1);
      tick();
    end
    a_hold = 1'b0;
    s0_tvalid = 1'b0;
    send(1'b0, 16'h5678);
    drain("t4");

    // Output backpressure on requester 1 blocks the shared result path.
    do_reset();
    m1_hold = 1'b1;
    send(1'b1, 16'd11);
    send(1'b1, 16'd22);
    send(1'b0, 16'd33);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      found = m1_tvalid;
      if (!found) tick();
    end
    check("t5_m1_filled", 32'(found), 32'h1);
    for (int k = 0; k < 10; k++) begin
      check("t5_cv_r_blocked", 32'(cv_r_tready), 32'h0);
      check("t5_m0_empty", 32'(m0_tvalid), 32'h0);
      tick();
      @(negedge clk);
    end
    tick();
    m1_hold = 1'b0;
    drain("t5");
    check("t5_m1_count", 32'(got1.size()), 32'd2);
    check("t5_m0_count", 32'(got0.size()), 32'd1);

    // Orphan result with an empty tag FIFO.
    inj_dat = 32'h3F800000;
    tick();
    inject = 1'b1;
    @(negedge clk);
    check("t6_orphan_vld", 32'(cv_r_tvalid), 32'h1);
    check("t6_orphan_rdy", 32'(cv_r_tready), 32'h1);
    tick();
    inject = 1'b0;
    @(negedge clk);
    check("t6_err_orphan", 32'(err_orphan), 32'h1);
    check("t6_m0_dropped", 32'(m0_tvalid), 32'h0);
    check("t6_m1_dropped", 32'(m1_tvalid), 32'h0);
    repeat (3) tick();
    check("t6_err_sticky", 32'(err_orphan), 32'h1);

    // Random traffic, asynchronous reset mid-stream, more random traffic.
    rand_mode = 1'b1;
    rand_run(600);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    r_hold = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    rand_run(1500);
    rand_mode = 1'b0;
    r_hold = 1'b0;
    drain("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fixfloat_conv_sched.md
# fixfloat_conv_sched

Scheduler that shares one pipelined 32-bit int-to-float converter core (AXI-stream slave A / result master) between two 16-bit signed sample requesters in the FSK modem datapath. Typical requesters are the I and Q demodulator branches. The block arbitrates round-robin, sign-extends samples to 32 bits and tracks each in-flight sample's owner in a tag FIFO. It routes each converted float back to the requester that issued it, with backpressure in both directions.

## Interface
- `MAX_OUT`, default 16: maximum converter transactions in flight; power of 2, range 2–64.
- `CW`, default 5: width of `outstanding`; equals log2(`MAX_OUT`)+1.

Ports:
- `clk`  in  1  single clock; all logic rises on this edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s0_tvalid` / `s0_tready` / `s0_tdata`  in / out / in  1 / 1 / 16  requester 0 sample stream (signed two's complement).
- `s1_tvalid` / `s1_tready` / `s1_tdata`  in / out / in  1 / 1 / 16  requester 1 sample stream.
- `cv_a_tvalid` / `cv_a_tready` / `cv_a_tdata`  out / in / out  1 / 1 / 32  to converter input A.
- `cv_r_tvalid` / `cv_r_tready` / `cv_r_tdata`  in / out / in  1 / 1 / 32  from converter result.
- `m0_tvalid` / `m0_tready` / `m0_tdata`  out / in / out  1 / 1 / 32  float result to requester 0.
- `m1_tvalid` / `m1_tready` / `m1_tdata`  out / in / out  1 / 1 / 32  float result to requester 1.
- `outstanding`  out  CW  samples accepted but not yet handed back to the result registers.
- `err_orphan`  out  1  sticky flag: a converter result arrived with the tag FIFO empty.

## Operation
- **Issue register.** Holds {`cv_a_tvalid`, `cv_a_tdata`}.
  - It can load when empty, or when `cv_a_tvalid && cv_a_tready` occurs in the same cycle.
  - It holds data stable while `cv_a_tvalid && !cv_a_tready`.
- **Credit gate.** A new sample is accepted only if the issue register can load and `outstanding < MAX_OUT`. There is no same-cycle credit bypass.
- **Arbitration.**
  - `rr` pointer resets to 0.
  - If only one requester is valid, it is granted.
  - If both are valid, requester `rr` is granted.
  - After every grant, `rr` becomes the non-granted index.
  - `sX_tready` is combinational: it equals grant X. At most one `sX_tready` is high per cycle.
- **Accept.** On an accepted sample:
  - The issue register loads `{{16{sX_tdata[15]}}, sX_tdata}`.
  - Tag X (1 bit) is pushed into the tag FIFO (depth `MAX_OUT`).
  - `outstanding` increments.
- **Result acceptance.**
  - `cv_r_tready` is high when the tag FIFO is non-empty, the head-tag destination register is empty or draining this cycle (`mX_tvalid && mX_tready`), and the block is not in reset.
  - `cv_r_tready` is also high when the tag FIFO is empty; the result is then dropped and `err_orphan` is set.
- **Result routing.** On `cv_r_tvalid && cv_r_tready` with the FIFO non-empty:
  - The head tag is popped.
  - `mX_tdata <= cv_r_tdata` and `mX_tvalid <= 1`.
  - `outstanding` decrements.
- `outstanding` handles a simultaneous increment and decrement as net zero.
- **Output registers.** `mX_tvalid` holds until `mX_tready`. `mX_tdata` holds stable while valid.
- **Ordering.** The converter returns results in issue order. Each requester receives results in its own submission order.
- **Reset.** While `rst_n` is low, and immediately after it goes low:
  - `cv_a_tvalid`, `cv_r_tready`, `m0_tvalid`, `m1_tvalid`, `s0_tready`, `s1_tready` are 0.
  - `outstanding` and `err_orphan` are 0; all data registers are 0.
  - The tag FIFO is empty and `rr` is 0.
- **Mid-operation reset.** Samples in flight are discarded. The converter must be reset alongside this block; results arriving afterwards are counted as orphans.

## Timing
- Sample accept in cycle N → `cv_a_tvalid` high in cycle N+1.
- Result handshake in cycle M → `mX_tvalid` high in cycle M+1.
- End-to-end latency: converter latency L + 2 cycles.
- Throughput: 1 sample per cycle total when `cv_a_tready` and both `mX_tready` stay high and `MAX_OUT` ≥ L+2.
- With both requesters valid continuously, grants alternate 0,1,0,1… each cycle.
- At `outstanding == MAX_OUT`, both `sX_tready` stay low until the cycle after a result pop.
- If the head-tag destination is stalled, `cv_r_tready` drops. Results for the other requester also wait; head-of-line blocking is accepted behaviour.

## Test plan
- **Single sample, requester 0.** Converter model latency 6, all readies high. Drive s0 `16'h8000`.
  - `cv_a_tdata` = `32'hFFFF8000` at N+1.
  - `m0_tdata` = `32'hC7000000` at N+8.
  - `m1_tvalid` never rises.
- **Both requesters streaming.** s0 sends 1,2,3 and s1 sends −1,−2,−3, both valid continuously.
  - Grant order is s0,s1,s0,s1,s0,s1.
  - m0 receives 1.0,2.0,3.0 and m1 receives −1.0,−2.0,−3.0, each in order.
- **Credit limit.** Hold `cv_r_tvalid` low, stream 20 samples on s0.
  - Exactly 16 are accepted; `outstanding` = 16 and `s0_tready` = 0.
  - Release results → the 17th sample is accepted the cycle after the first pop.
- **Converter stall.** Hold `cv_a_tready` low for 5 cycles with a sample loaded.
  - `cv_a_tdata` is stable, no further accepts occur, and `outstanding` stays at 1.
- **Output backpressure.** Hold `m1_tready` low with results pending for s1 then s0.
  - `cv_r_tready` stays 0 after m1 fills, and m0 stays empty until `m1_tready` rises.
  - No result is lost or duplicated.
- **Orphan and reset.**
  - Inject `cv_r_tvalid` with an empty FIFO → `err_orphan` = 1 and the result is dropped.
  - Assert `rst_n` = 0 mid-stream → all outputs clear within the same cycle, and `err_orphan` = 0.
